// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush scheduler:
//   - L_OP          : RV32I load opcode, used for load-use detection
//   - pctrl_state_e : scheduler FSM state (2-bit)
//   - STALL_*       : bit indices into stall_o
// No ports (package).
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam logic [6:0] L_OP = 7'b0000011;

    typedef enum logic [1:0] {
        PCTRL_RUN      = 2'd0,
        PCTRL_REDIRECT = 2'd1,
        PCTRL_MEM_WAIT = 2'd2
    } pctrl_state_e;

    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles every pipeline-side signal of pipeline_ctrl (everything except
// clk/rst). The slave modport is the scheduler; the master modport is the
// pipeline datapath that feeds it and obeys its stall/flush/redirect outputs.
// Signals are level-sampled every clock; there is no valid/ready handshake:
// each output is a per-cycle command that applies in the cycle it is high.
// Optional macro PIPE_CTRL_PERF_EN adds three 32-bit performance counters.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
);
    logic              rdy;
    logic              id_reg1_read_i;
    logic [REG_AW-1:0] id_reg1_addr_i;
    logic              id_reg2_read_i;
    logic [REG_AW-1:0] id_reg2_addr_i;
    logic              id_branch_en_i;
    logic [ADDR_W-1:0] id_branch_addr_i;
    logic [6:0]        exe_op_i;
    logic              exe_wreg_i;
    logic [REG_AW-1:0] exe_wd_i;
    logic              if_busy_i;
    logic              mem_busy_i;
    logic [4:0]        stall_o;
    logic              bubble_id_ex_o;
    logic              flush_if_id_o;
    logic              pc_redirect_o;
    logic [ADDR_W-1:0] pc_target_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]       perf_stall_cnt_o;
    logic [31:0]       perf_flush_cnt_o;
    logic [31:0]       perf_lu_cnt_o;
`endif

    modport slave (
        input  rdy, id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
        input  id_branch_en_i, id_branch_addr_i, exe_op_i, exe_wreg_i, exe_wd_i,
        input  if_busy_i, mem_busy_i,
`ifdef PIPE_CTRL_PERF_EN
        output perf_stall_cnt_o, perf_flush_cnt_o, perf_lu_cnt_o,
`endif
        output stall_o, bubble_id_ex_o, flush_if_id_o, pc_redirect_o, pc_target_o
    );

    modport master (
        output rdy, id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
        output id_branch_en_i, id_branch_addr_i, exe_op_i, exe_wreg_i, exe_wd_i,
        output if_busy_i, mem_busy_i,
`ifdef PIPE_CTRL_PERF_EN
        input  perf_stall_cnt_o, perf_flush_cnt_o, perf_lu_cnt_o,
`endif
        input  stall_o, bubble_id_ex_o, flush_if_id_o, pc_redirect_o, pc_target_o
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_hazard_unit
// Combinational load-use detector: high when the instruction in EX is a load
// writing a non-x0 register that the instruction in ID reads.
// Ports:
//   reg1_read/reg1_addr, reg2_read/reg2_addr : ID source operands
//   exe_op, exe_wreg, exe_wd                 : EX opcode / write enable / rd
//   load_use                                 : hazard detected
// ---------------------------------------------------------------------------
module pipeline_ctrl_hazard_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              reg1_read,
    input  logic [REG_AW-1:0] reg1_addr,
    input  logic              reg2_read,
    input  logic [REG_AW-1:0] reg2_addr,
    input  logic [6:0]        exe_op,
    input  logic              exe_wreg,
    input  logic [REG_AW-1:0] exe_wd,
    output logic              load_use
);
    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = exe_wreg && (exe_op == L_OP) && (exe_wd != '0) &&
                      ((reg1_read && (reg1_addr == exe_wd)) ||
                       (reg2_read && (reg2_addr == exe_wd)));
endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush scheduler for the 5-stage RV32I pipeline.
// Ports:
//   clk          : clock
//   rst          : synchronous active-low reset
//   pif (slave)  : pipeline signals (rdy, ID operands/branch, EX load info,
//                  fetch/mem busy in; stall_o, bubble, flush, redirect,
//                  target out)
//   dbg_state_o  : current FSM state, for observation only
// Outputs are Mealy (combinational in state and inputs) so every hazard
// takes effect in the cycle it is detected.
// Optional macro PIPE_CTRL_PERF_EN adds stall/flush/load-use counters.
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave pif,
    output pctrl_state_e   dbg_state_o
);
    pctrl_state_e      state, state_nx;
    logic [ADDR_W-1:0] target_q;
    logic              load_use;
    logic              take_branch;

    pipeline_ctrl_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .reg1_read (pif.id_reg1_read_i),
        .reg1_addr (pif.id_reg1_addr_i),
        .reg2_read (pif.id_reg2_read_i),
        .reg2_addr (pif.id_reg2_addr_i),
        .exe_op    (pif.exe_op_i),
        .exe_wreg  (pif.exe_wreg_i),
        .exe_wd    (pif.exe_wd_i),
        .load_use  (load_use)
    );

    // A branch is accepted only outside REDIRECT, and loses to both a busy
    // memory stage and a load-use hazard (ID re-presents it later).
    assign take_branch = (state != PCTRL_REDIRECT) && !pif.mem_busy_i &&
                         !load_use && pif.id_branch_en_i;

    assign dbg_state_o = state;

    // State and target register; rdy low freezes both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= PCTRL_RUN;
            target_q <= '0;
        end else if (pif.rdy) begin
            state <= state_nx;
            if (take_branch) target_q <= pif.id_branch_addr_i;
        end
    end

    // Next-state logic. MEM_WAIT with mem_busy low falls straight into the
    // RUN rules, so both states share one branch of the case.
    always_comb begin
        state_nx = state;
        case (state)
            PCTRL_RUN, PCTRL_MEM_WAIT: begin
                if (pif.mem_busy_i)  state_nx = PCTRL_MEM_WAIT;
                else if (take_branch) state_nx = pif.if_busy_i ? PCTRL_REDIRECT : PCTRL_RUN;
                else                  state_nx = PCTRL_RUN;
            end
            PCTRL_REDIRECT: begin
                if (!pif.if_busy_i) state_nx = pif.mem_busy_i ? PCTRL_MEM_WAIT : PCTRL_RUN;
            end
            default: state_nx = PCTRL_RUN;
        endcase
    end

    // Output logic.
    always_comb begin
        pif.stall_o        = '0;
        pif.bubble_id_ex_o = 1'b0;
        pif.flush_if_id_o  = 1'b0;
        pif.pc_redirect_o  = 1'b0;
        pif.pc_target_o    = target_q;
        if (!rst) begin
            pif.pc_target_o = '0;
        end else if (!pif.rdy) begin
            pif.stall_o = '1;
        end else begin
            case (state)
                PCTRL_RUN, PCTRL_MEM_WAIT: begin
                    if (pif.mem_busy_i) begin
                        pif.stall_o[STALL_PC]     = 1'b1;
                        pif.stall_o[STALL_IF_ID]  = 1'b1;
                        pif.stall_o[STALL_ID_EX]  = 1'b1;
                        pif.stall_o[STALL_EX_MEM] = 1'b1;
                    end else if (load_use) begin
                        pif.stall_o[STALL_PC]    = 1'b1;
                        pif.stall_o[STALL_IF_ID] = 1'b1;
                        pif.bubble_id_ex_o       = 1'b1;
                    end else if (take_branch) begin
                        pif.pc_redirect_o = 1'b1;
                        pif.flush_if_id_o = 1'b1;
                        // Bypass so the PC sees the target in the same cycle.
                        pif.pc_target_o   = pif.id_branch_addr_i;
                    end
                end
                PCTRL_REDIRECT: begin
                    pif.stall_o[STALL_PC]    = 1'b1;
                    pif.stall_o[STALL_IF_ID] = 1'b1;
                    if (pif.mem_busy_i) begin
                        pif.stall_o[STALL_ID_EX]  = 1'b1;
                        pif.stall_o[STALL_EX_MEM] = 1'b1;
                    end
                    // The stale fetch returns this cycle; drop it.
                    pif.flush_if_id_o = !pif.if_busy_i;
                end
                default: pif.stall_o[STALL_MEM_WB] = 1'b0;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, lu_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (pif.rdy && pif.stall_o[STALL_PC]) stall_cnt <= stall_cnt + 32'd1;
            if (pif.flush_if_id_o)                flush_cnt <= flush_cnt + 32'd1;
            if (pif.bubble_id_ex_o)               lu_cnt    <= lu_cnt + 32'd1;
        end
    end

    assign pif.perf_stall_cnt_o = stall_cnt;
    assign pif.perf_flush_cnt_o = flush_cnt;
    assign pif.perf_lu_cnt_o    = lu_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed scenarios followed by random traffic, all checked each cycle
// against a behavioural model of the scheduler rules.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int W = 40;  // {stall[4:0], bubble, flush, redirect, target[31:0]}

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    pctrl_state_e dbg_state;

    pipeline_ctrl_if #(.ADDR_W(32), .REG_AW(5)) pif ();

    pipeline_ctrl #(.ADDR_W(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .pif         (pif),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // fetch_pending: a redirect is waiting for the old fetch to return.
    // mem_frozen   : previous cycle ended with the memory stage busy.
    bit          fetch_pending, mem_frozen;
    logic [31:0] m_target;
    logic [31:0] m_stall_cnt, m_flush_cnt, m_lu_cnt;

    function automatic bit model_load_use();
        bit is_load = pif.exe_wreg_i && (pif.exe_op_i == L_OP) && (pif.exe_wd_i != 5'd0);
        bit rs1_hit = pif.id_reg1_read_i && (pif.id_reg1_addr_i == pif.exe_wd_i);
        bit rs2_hit = pif.id_reg2_read_i && (pif.id_reg2_addr_i == pif.exe_wd_i);
        return is_load && (rs1_hit || rs2_hit);
    endfunction

    // One clock: evaluate model at negedge, compare, then advance at posedge.
    task automatic cycle();
        logic [4:0]  e_st;
        logic        e_b, e_f, e_r;
        logic [31:0] e_t;
        bit          n_pend, n_frz;
        logic [31:0] n_tgt;
        logic [W-1:0] e;
        logic [1:0]  e_state;

        @(negedge clk);
        e_st = 5'd0; e_b = 1'b0; e_f = 1'b0; e_r = 1'b0; e_t = m_target;
        n_pend = fetch_pending; n_frz = mem_frozen; n_tgt = m_target;
        e_state = fetch_pending ? PCTRL_REDIRECT : (mem_frozen ? PCTRL_MEM_WAIT : PCTRL_RUN);

        if (!rst) begin
            e_t = 32'd0;
            n_pend = 0; n_frz = 0; n_tgt = 32'd0;
        end else if (!pif.rdy) begin
            e_st = 5'b11111;
        end else if (fetch_pending) begin
            e_st = pif.mem_busy_i ? 5'b01111 : 5'b00011;
            e_f  = !pif.if_busy_i;
            if (!pif.if_busy_i) begin
                n_pend = 0;
                n_frz  = pif.mem_busy_i;
            end
        end else if (pif.mem_busy_i) begin
            e_st  = 5'b01111;
            n_frz = 1;
        end else if (model_load_use()) begin
            e_st  = 5'b00011;
            e_b   = 1'b1;
            n_frz = 0;
        end else if (pif.id_branch_en_i) begin
            e_r = 1'b1; e_f = 1'b1;
            e_t = pif.id_branch_addr_i;
            n_tgt  = pif.id_branch_addr_i;
            n_pend = pif.if_busy_i;
            n_frz  = 0;
        end else begin
            n_frz = 0;
        end

        exp_q.push_back({e_st, e_b, e_f, e_r, e_t});
        e = exp_q.pop_front();
        check_eq("stall",    32'(pif.stall_o),        32'(e[39:35]));
        check_eq("bubble",   32'(pif.bubble_id_ex_o), 32'(e[34]));
        check_eq("flush",    32'(pif.flush_if_id_o),  32'(e[33]));
        check_eq("redirect", 32'(pif.pc_redirect_o),  32'(e[32]));
        check_eq("target",   pif.pc_target_o,         e[31:0]);
        if (rst) check_eq("state", 32'(dbg_state), 32'(e_state));
`ifdef PIPE_CTRL_PERF_EN
        check_eq("perf_stall", pif.perf_stall_cnt_o, m_stall_cnt);
        check_eq("perf_flush", pif.perf_flush_cnt_o, m_flush_cnt);
        check_eq("perf_lu",    pif.perf_lu_cnt_o,    m_lu_cnt);
`endif

        @(posedge clk);
        #1;
        if (!rst) begin
            m_stall_cnt = 32'd0; m_flush_cnt = 32'd0; m_lu_cnt = 32'd0;
        end else begin
            if (pif.rdy && e_st[0]) m_stall_cnt = m_stall_cnt + 32'd1;
            if (e_f)                m_flush_cnt = m_flush_cnt + 32'd1;
            if (e_b)                m_lu_cnt    = m_lu_cnt + 32'd1;
        end
        fetch_pending = n_pend;
        mem_frozen    = n_frz;
        m_target      = n_tgt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        pif.rdy = 1'b1;
        pif.id_reg1_read_i = 1'b0; pif.id_reg1_addr_i = 5'd0;
        pif.id_reg2_read_i = 1'b0; pif.id_reg2_addr_i = 5'd0;
        pif.id_branch_en_i = 1'b0; pif.id_branch_addr_i = 32'd0;
        pif.exe_op_i = 7'd0; pif.exe_wreg_i = 1'b0; pif.exe_wd_i = 5'd0;
        pif.if_busy_i = 1'b0; pif.mem_busy_i = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1);
        pif.exe_op_i = L_OP; pif.exe_wreg_i = 1'b1; pif.exe_wd_i = rd;
        pif.id_reg1_read_i = 1'b1; pif.id_reg1_addr_i = rs1;
    endtask

    task automatic drive_random();
        rst = ($urandom_range(0, 49) != 0);
        pif.rdy = ($urandom_range(0, 9) != 0);
        pif.id_reg1_read_i = 1'($urandom_range(0, 1));
        pif.id_reg1_addr_i = 5'($urandom_range(0, 3));
        pif.id_reg2_read_i = 1'($urandom_range(0, 1));
        pif.id_reg2_addr_i = 5'($urandom_range(0, 3));
        pif.id_branch_en_i = ($urandom_range(0, 2) == 0);
        pif.id_branch_addr_i = $urandom;
        pif.exe_op_i = ($urandom_range(0, 1) != 0) ? L_OP : 7'($urandom_range(0, 127));
        pif.exe_wreg_i = ($urandom_range(0, 3) != 0);
        pif.exe_wd_i = 5'($urandom_range(0, 3));
        pif.if_busy_i = 1'($urandom_range(0, 1));
        pif.mem_busy_i = ($urandom_range(0, 4) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        fetch_pending = 0; mem_frozen = 0; m_target = 32'd0;
        m_stall_cnt = 32'd0; m_flush_cnt = 32'd0; m_lu_cnt = 32'd0;
        rst = 1'b0;
        @(posedge clk); #1;
        cycle();                       // reset state, outputs all zero
        rst = 1'b1;
        cycle();

        // 1. load-use on rs1, then rd=x0 and a non-matching rs1
        set_load(5'd5, 5'd5); cycle();
        set_load(5'd0, 5'd0); cycle();
        set_load(5'd5, 5'd6); cycle();
        set_idle();

        // 2. branch while fetch busy, fetch returns three cycles later
        pif.id_branch_en_i = 1'b1; pif.id_branch_addr_i = 32'h100; pif.if_busy_i = 1'b1;
        cycle();
        pif.id_branch_en_i = 1'b1; pif.id_branch_addr_i = 32'h200;  // ignored in REDIRECT
        cycle();
        pif.id_branch_en_i = 1'b0;
        cycle();
        pif.if_busy_i = 1'b0;
        cycle();
        cycle();

        // 3. memory busy for 4 cycles, released in the 5th
        pif.mem_busy_i = 1'b1;
        repeat (4) cycle();
        pif.mem_busy_i = 1'b0;
        cycle();

        // 4. load-use and branch together, then branch alone
        set_load(5'd7, 5'd7);
        pif.id_branch_en_i = 1'b1; pif.id_branch_addr_i = 32'h300;
        cycle();
        pif.exe_wreg_i = 1'b0;
        cycle();
        set_idle();
        cycle();

        // 5. rdy low in MEM_WAIT, then reset while in REDIRECT
        pif.mem_busy_i = 1'b1;
        cycle();
        pif.rdy = 1'b0;
        repeat (2) cycle();
        pif.rdy = 1'b1; pif.mem_busy_i = 1'b0;
        cycle();
        pif.id_branch_en_i = 1'b1; pif.id_branch_addr_i = 32'h400; pif.if_busy_i = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        set_idle();
        cycle();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
